// File: rtl/vid_row_packer.sv
// rtl/vid_row_packer.sv - packs a serial vertex-ID stream into Q-lane SRAM rows
module vid_row_packer #(
    parameter int ADDR_SPACE = 5,
    parameter int Q          = 16,
    parameter int VID_BW     = 16,
    parameter int DEPTH      = 16,
    parameter logic [VID_BW-1:0] PAD = {VID_BW{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  vid_valid,
    input  logic [VID_BW-1:0]     vid_in,
    input  logic                  vid_last,
    output logic                  vid_ready,
    output logic                  wsb,
    output logic [ADDR_SPACE-1:0] waddr,
    output logic [VID_BW*Q-1:0]   wdata,
    output logic [ADDR_SPACE:0]   rows_written,
    output logic                  done,
    output logic                  overflow
);
    localparam int LANE_W = (Q > 1) ? $clog2(Q) : 1;
    localparam int CNT_W  = ADDR_SPACE + 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   lane_idx;
    logic [CNT_W-1:0]    row_cnt;
    logic [VID_BW*Q-1:0] row_buf, row_nxt;
    logic                full, xfer, row_done, job_start;

    assign full         = row_cnt >= CNT_W'(DEPTH);
    assign vid_ready    = (state == FILL) && !full;
    assign xfer         = vid_valid && vid_ready;
    assign row_done     = xfer && (vid_last || lane_idx == LANE_W'(Q - 1));
    assign job_start    = start && (state != FILL);
    assign done         = (state == DONE);
    assign rows_written = row_cnt;

    // Row as it would look if written now: filled lanes, current ID, PAD above
    always_comb begin
        row_nxt = row_buf;
        for (int k = 0; k < Q; k++) begin
            if (LANE_W'(k) == lane_idx)
                row_nxt[k*VID_BW +: VID_BW] = vid_in;
            else if (LANE_W'(k) > lane_idx)
                row_nxt[k*VID_BW +: VID_BW] = PAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FILL;
            // vid_last ends the job whether or not a row is still available
            FILL:       if (vid_valid && vid_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsb      <= 1'b1;
            waddr    <= '0;
            wdata    <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
            lane_idx <= '0;
            row_buf  <= '0;
        end else begin
            wsb <= 1'b1;
            if (job_start) begin
                lane_idx <= '0;
                row_cnt  <= '0;
                overflow <= 1'b0;
                row_buf  <= '0;
            end else if (row_done) begin
                wsb      <= 1'b0;
                waddr    <= row_cnt[ADDR_SPACE-1:0];
                wdata    <= row_nxt;
                row_cnt  <= row_cnt + 1'b1;
                lane_idx <= '0;
                row_buf  <= '0;
            end else if (xfer) begin
                row_buf  <= row_nxt;
                lane_idx <= lane_idx + 1'b1;
            end
            if (state == FILL && full && vid_valid)
                overflow <= 1'b1;
        end
    end
endmodule
